program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction loader that fills CPU instruction memory
//
// Purpose: receives a program as a stream of byte pairs (low byte, then a high
// byte whose bit 0 is instruction bit 8). Each pair becomes one 9-bit word
// written to instruction memory. The CPU is held in reset until a complete
// program has been written.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       begin a load (sampled in IDLE and DONE only)
//   abort       cancel an in-progress load (ignored in IDLE and DONE)
//   prog_len    instruction count, clamped to 256
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_ready    byte-stream ready (LO and HI)
//   imem_we     instruction-memory write strobe
//   imem_addr   instruction-memory write address
//   imem_wdata  instruction word
//   cpu_reset   CPU reset, low only in DONE
//   busy        high in LO, HI and WRITE
//   done        high in DONE
//   err         sticky format error, cleared by start
module program_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [8:0] prog_len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       imem_we,
    output logic [7:0] imem_addr,
    output logic [8:0] imem_wdata,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    logic [8:0] r_len;
    logic [8:0] r_count;
    logic [7:0] r_lo;
    logic       r_hi;
    logic       r_err;

    logic [8:0] w_len_clamped;
    logic [8:0] w_count_next;
    logic       w_xfer;

    assign w_len_clamped = (prog_len > 9'd256) ? 9'd256 : prog_len;
    assign w_count_next  = r_count + 9'd1;
    assign w_xfer        = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_len   <= 9'd0;
            r_count <= 9'd0;
            r_lo    <= 8'd0;
            r_hi    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_count <= 9'd0;
                        r_err   <= 1'b0;
                        r_state <= (w_len_clamped == 9'd0) ? S_DONE : S_LO;
                    end
                end
                S_LO: begin
                    // abort wins over a simultaneous transfer; that byte is dropped
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_xfer) begin
                        r_lo    <= in_data;
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_xfer) begin
                        r_hi <= in_data[0];
                        if (in_data[7:1] != 7'd0) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= w_count_next;
                        r_state <= (w_count_next == r_len) ? S_DONE : S_LO;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_LO) || (r_state == S_HI);
    // abort in WRITE cancels the strobe within the same cycle
    assign imem_we    = (r_state == S_WRITE) && !abort;
    assign imem_addr  = r_count[7:0];
    assign imem_wdata = {r_hi, r_lo};
    assign cpu_reset  = (r_state != S_DONE);
    assign busy       = (r_state == S_LO) || (r_state == S_HI) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [8:0] prog_len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [8:0] imem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;

    int total;
    int bad;

    int         wr_count;
    logic [7:0] log_addr [0:511];
    logic [8:0] log_data [0:511];

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .prog_len   (prog_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_count < 512) begin
                log_addr[wr_count] = imem_addr;
                log_data[wr_count] = imem_wdata;
            end
            wr_count = wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%0h want=1", cpu_reset); end
        total++; if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {in_ready, imem_we, busy, done, err}); end
        total++; if ({imem_addr, imem_wdata} !== 17'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {imem_addr, imem_wdata}); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wr_count = 0;
        pulse_start(9'd1);
        total++; if ({busy, in_ready, cpu_reset} !== 3'b111) begin bad++; $display("FAIL single_lo got=%b want=111", {busy, in_ready, cpu_reset}); end
        send_byte(8'hA5);
        send_byte(8'h01);
        total++; if ({imem_we, in_ready} !== 2'b10) begin bad++; $display("FAIL single_write_strobe got=%b want=10", {imem_we, in_ready}); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL single_addr got=%h want=00", imem_addr); end
        total++; if (imem_wdata !== 9'h1A5) begin bad++; $display("FAIL single_wdata got=%h want=1a5", imem_wdata); end
        tick();
        total++; if ({done, cpu_reset, err, busy} !== 4'b1000) begin bad++; $display("FAIL single_done got=%b want=1000", {done, cpu_reset, err, busy}); end
        total++; if (wr_count !== 1) begin bad++; $display("FAIL single_wr_count got=%0d want=1", wr_count); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if ({done, cpu_reset} !== 2'b10) begin bad++; $display("FAIL done_abort_ignored got=%b want=10", {done, cpu_reset}); end
    endtask

    task automatic test_full();
        int not_busy;
        logic [31:0] iv;
        logic [8:0]  exp;
        wr_count = 0;
        not_busy = 0;
        pulse_start(9'd300);
        for (int i = 0; i < 256; i++) begin
            iv = i;
            if (busy !== 1'b1) not_busy++;
            send_byte(iv[7:0]);
            if (busy !== 1'b1) not_busy++;
            send_byte({7'd0, iv[0]});
            if (busy !== 1'b1) not_busy++;
            tick();
        end
        total++; if (not_busy !== 0) begin bad++; $display("FAIL full_busy got=%0d want=0", not_busy); end
        total++; if ({done, cpu_reset} !== 2'b10) begin bad++; $display("FAIL full_done got=%b want=10", {done, cpu_reset}); end
        tick();
        tick();
        total++; if (wr_count !== 256) begin bad++; $display("FAIL full_wr_count got=%0d want=256", wr_count); end
        for (int i = 0; i < 256; i++) begin
            iv  = i;
            exp = {iv[0], iv[7:0]};
            total++; if (log_addr[i] !== iv[7:0] || log_data[i] !== exp) begin bad++; $display("FAIL full_word%0d got=%h/%h want=%h/%h", i, log_addr[i], log_data[i], iv[7:0], exp); end
        end
    endtask

    task automatic test_stall();
        int ready_bad;
        wr_count  = 0;
        ready_bad = 0;
        pulse_start(9'd2);
        for (int w = 0; w < 2; w++) begin
            tick();
            if ({in_ready, busy} !== 2'b11) ready_bad++;
            send_byte(w == 0 ? 8'h3C : 8'hC3);
            tick();
            if ({in_ready, busy} !== 2'b11) ready_bad++;
            send_byte(w == 0 ? 8'h00 : 8'h01);
            if ({in_ready, imem_we} !== 2'b01) ready_bad++;
            tick();
        end
        total++; if (ready_bad !== 0) begin bad++; $display("FAIL stall_ready got=%0d want=0", ready_bad); end
        total++; if (wr_count !== 2) begin bad++; $display("FAIL stall_wr_count got=%0d want=2", wr_count); end
        total++; if (log_addr[0] !== 8'h00 || log_data[0] !== 9'h03C) begin bad++; $display("FAIL stall_word0 got=%h/%h want=00/03c", log_addr[0], log_data[0]); end
        total++; if (log_addr[1] !== 8'h01 || log_data[1] !== 9'h1C3) begin bad++; $display("FAIL stall_word1 got=%h/%h want=01/1c3", log_addr[1], log_data[1]); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%0h want=1", done); end
    endtask

    task automatic test_format_err();
        wr_count = 0;
        pulse_start(9'd1);
        send_byte(8'h55);
        send_byte(8'h83);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL fmt_err_set got=%0h want=1", err); end
        total++; if (imem_wdata !== 9'h155 || imem_we !== 1'b1) begin bad++; $display("FAIL fmt_wdata got=%h we=%0h want=155 we=1", imem_wdata, imem_we); end
        tick();
        total++; if ({done, err} !== 2'b11) begin bad++; $display("FAIL fmt_err_done got=%b want=11", {done, err}); end
        pulse_start(9'd1);
        total++; if ({err, cpu_reset, busy} !== 3'b011) begin bad++; $display("FAIL fmt_err_clear got=%b want=011", {err, cpu_reset, busy}); end
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
    endtask

    task automatic test_abort();
        wr_count = 0;
        pulse_start(9'd5);
        prog_len = 9'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        total++; if ({in_ready, busy, done} !== 3'b110) begin bad++; $display("FAIL start_ignored got=%b want=110", {in_ready, busy, done}); end
        for (int w = 0; w < 3; w++) begin
            send_byte(8'h10 + 8'(w));
            send_byte(8'h00);
            tick();
        end
        send_byte(8'h20);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        total++; if ({busy, done, cpu_reset, in_ready} !== 4'b0010) begin bad++; $display("FAIL abort_idle got=%b want=0010", {busy, done, cpu_reset, in_ready}); end
        tick();
        tick();
        total++; if (wr_count !== 3) begin bad++; $display("FAIL abort_wr_count got=%0d want=3", wr_count); end
        wr_count = 0;
        pulse_start(9'd2);
        send_byte(8'h77);
        send_byte(8'h00);
        abort = 1'b1;
        #1;
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL abort_write_suppress got=%0h want=0", imem_we); end
        tick();
        abort = 1'b0;
        total++; if ({busy, wr_count[1:0]} !== 3'b000) begin bad++; $display("FAIL abort_write_idle got=%b want=000", {busy, wr_count[1:0]}); end
    endtask

    task automatic test_reset_mid();
        wr_count = 0;
        pulse_start(9'd2);
        send_byte(8'hEE);
        send_byte(8'h01);
        total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL rstmid_pre_we got=%0h want=1", imem_we); end
        reset = 1'b0;
        #1;
        total++; if ({imem_we, in_ready, busy, done, err, cpu_reset} !== 6'b000001) begin bad++; $display("FAIL rstmid_flags got=%b want=000001", {imem_we, in_ready, busy, done, err, cpu_reset}); end
        total++; if ({imem_addr, imem_wdata} !== 17'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0", {imem_addr, imem_wdata}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if ({cpu_reset, wr_count[1:0]} !== 3'b100) begin bad++; $display("FAIL rstmid_release got=%b want=100", {cpu_reset, wr_count[1:0]}); end
        pulse_start(9'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start got=%0h want=1", busy); end
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
    endtask

    task automatic test_zero_reload();
        wr_count = 0;
        pulse_start(9'd0);
        total++; if ({done, cpu_reset, busy} !== 3'b100) begin bad++; $display("FAIL zero_done got=%b want=100", {done, cpu_reset, busy}); end
        tick();
        total++; if (wr_count !== 0) begin bad++; $display("FAIL zero_no_write got=%0d want=0", wr_count); end
        pulse_start(9'd1);
        total++; if ({cpu_reset, busy, done} !== 3'b110) begin bad++; $display("FAIL reload_reset got=%b want=110", {cpu_reset, busy, done}); end
        send_byte(8'h11);
        send_byte(8'h00);
        tick();
        total++; if (wr_count !== 1 || log_addr[0] !== 8'h00 || log_data[0] !== 9'h011) begin bad++; $display("FAIL reload_word got=%0d/%h/%h want=1/00/011", wr_count, log_addr[0], log_data[0]); end
        total++; if ({done, cpu_reset} !== 2'b10) begin bad++; $display("FAIL reload_done got=%b want=10", {done, cpu_reset}); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        wr_count = 0;
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        prog_len = 9'd0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single();
        test_full();
        test_stall();
        test_format_err();
        test_abort();
        test_reset_mid();
        test_zero_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
